// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the MEM-stage load/store unit.
//   lsu_state_e : FSM states (idle, request, wait-for-response, done)
//   lsu_size_e  : access size decoded from funct3[1:0]
//   OPC_LOAD    : load opcode, F3_LBU/F3_LHU : unsigned load funct3 codes
package lsu_pkg;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_e;
   typedef enum logic [1:0] {SizeByte, SizeHalf, SizeWord} lsu_size_e;

   localparam logic [6:0] OPC_LOAD = 7'b0000011;
   localparam logic [2:0] F3_LBU   = 3'b100;
   localparam logic [2:0] F3_LHU   = 3'b101;

   // Only funct3[1:0] matters; the reserved load encodings fall through to word.
   function automatic lsu_size_e decode_size(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return SizeByte;
         2'b01:   return SizeHalf;
         default: return SizeWord;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   addr_lo_i  : address bits [1:0]      funct3_i : access size / signedness
//   wdata_i    : raw store data          rdata_i  : raw bus read word
//   be_o       : byte enables            wdata_o  : lane-replicated store data
//   misalign_o : access not naturally aligned
//   ld_ext_o   : selected load lanes, sign/zero extended to 32 bits
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misalign_o,
   output logic [31:0] ld_ext_o
);

   lsu_size_e   size;
   logic        is_unsigned;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign size        = decode_size(funct3_i);
   assign is_unsigned = (funct3_i == F3_LBU) || (funct3_i == F3_LHU);
   assign rd_byte     = rdata_i[{addr_lo_i, 3'b000} +: 8];
   assign rd_half     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      be_o       = 4'b1111;
      wdata_o    = wdata_i;
      misalign_o = 1'b0;
      ld_ext_o   = rdata_i;
      case (size)
         SizeByte: begin
            be_o     = 4'b0001 << addr_lo_i;
            wdata_o  = {4{wdata_i[7:0]}};
            ld_ext_o = {{24{~is_unsigned & rd_byte[7]}}, rd_byte};
         end
         SizeHalf: begin
            be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o    = {2{wdata_i[15:0]}};
            misalign_o = addr_lo_i[0];
            ld_ext_o   = {{16{~is_unsigned & rd_half[15]}}, rd_half};
         end
         default: begin
            misalign_o = (addr_lo_i != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a req/gnt/rvalid data bus.
//   valid_i/instr_i/addr_i/wdata_i/memrw_i : EX/MEM pipeline inputs
//   stall_o    : freeze upstream stages while an access is in flight
//   ld_valid_o : one-cycle strobe, ld_data_o holds the extended load result
//   misalign_o : one-cycle strobe, misaligned access dropped without a bus cycle
//   bus_err_o  : one-cycle strobe, access aborted after TIMEOUT_CYCLES-1 bus cycles
//   dmem_*     : data-memory bus (word address, byte enables, replicated wdata)
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        memrw_i,
   output logic        stall_o,
   output logic        ld_valid_o,
   output logic [31:0] ld_data_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
   // Value held during the last permitted REQ/WAIT cycle.
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 2);

   lsu_state_e    state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]   data_q, data_d;
   logic          load_q, load_d;
   logic          err_q, err_d;

   logic          is_load, mem_op, misal, timeout, start;
   logic [3:0]    al_be;
   logic [31:0]   al_wdata, al_ld;
   logic          unused_instr;

   assign unused_instr = ^{instr_i[31:15], instr_i[11:7]};

   assign is_load = ~memrw_i & (instr_i[6:0] == OPC_LOAD);
   assign mem_op  = valid_i & (is_load | memrw_i);
   assign timeout = (cnt_q == CntLast);
   assign start   = (state_q == StIdle) & mem_op & ~misal;

   lsu_align u_align (
      .addr_lo_i  (addr_i[1:0]),
      .funct3_i   (instr_i[14:12]),
      .wdata_i    (wdata_i),
      .rdata_i    (dmem_rdata_i),
      .be_o       (al_be),
      .wdata_o    (al_wdata),
      .misalign_o (misal),
      .ld_ext_o   (al_ld)
   );

   // State register plus datapath registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         data_q  <= '0;
         load_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         load_q  <= load_d;
         err_q   <= err_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      load_d  = load_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StReq;
               cnt_d   = '0;
               load_d  = is_load;
               err_d   = 1'b0;
            end
         end
         StReq: begin
            cnt_d = cnt_q + 1'b1;
            // A grant in the final cycle still counts as a timeout: nothing completed.
            if (timeout) begin
               state_d = StDone;
               err_d   = 1'b1;
               data_d  = '0;
            end else if (dmem_gnt_i) begin
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (dmem_rvalid_i) begin
               state_d = StDone;
               data_d  = load_q ? al_ld : '0;
            end else if (timeout) begin
               state_d = StDone;
               err_d   = 1'b1;
               data_d  = '0;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output decode.
   always_comb begin
      stall_o      = 1'b0;
      ld_valid_o   = 1'b0;
      misalign_o   = 1'b0;
      bus_err_o    = 1'b0;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_be_o    = '0;
      dmem_wdata_o = '0;
      unique case (state_q)
         StIdle: begin
            stall_o    = start;
            misalign_o = mem_op & misal;
         end
         StReq: begin
            stall_o      = 1'b1;
            dmem_req_o   = 1'b1;
            dmem_we_o    = ~load_q;
            dmem_addr_o  = {addr_i[31:2], 2'b00};
            dmem_be_o    = al_be;
            dmem_wdata_o = load_q ? '0 : al_wdata;
         end
         StWait: stall_o = 1'b1;
         StDone: begin
            ld_valid_o = load_q & ~err_q;
            bus_err_o  = err_q;
         end
         default: ;
      endcase
   end

   assign ld_data_o = data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

   localparam int T = 4;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpAlu   = 7'b0110011;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i;
   logic [31:0] instr_i, addr_i, wdata_i;
   logic        memrw_i;
   logic        stall_o, ld_valid_o, misalign_o, bus_err_o;
   logic [31:0] ld_data_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .valid_i       (valid_i),
      .instr_i       (instr_i),
      .addr_i        (addr_i),
      .wdata_i       (wdata_i),
      .memrw_i       (memrw_i),
      .stall_o       (stall_o),
      .ld_valid_o    (ld_valid_o),
      .ld_data_o     (ld_data_o),
      .misalign_o    (misalign_o),
      .bus_err_o     (bus_err_o),
      .dmem_req_o    (dmem_req_o),
      .dmem_we_o     (dmem_we_o),
      .dmem_addr_o   (dmem_addr_o),
      .dmem_be_o     (dmem_be_o),
      .dmem_wdata_o  (dmem_wdata_o),
      .dmem_gnt_i    (dmem_gnt_i),
      .dmem_rvalid_i (dmem_rvalid_i),
      .dmem_rdata_i  (dmem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
      check_eq({tag, "_req"}, 32'(dmem_req_o), 32'd0);
      check_eq({tag, "_we"}, 32'(dmem_we_o), 32'd0);
      check_eq({tag, "_addr"}, dmem_addr_o, 32'd0);
      check_eq({tag, "_be"}, 32'(dmem_be_o), 32'd0);
      check_eq({tag, "_wdata"}, dmem_wdata_o, 32'd0);
      check_eq({tag, "_ldv"}, 32'(ld_valid_o), 32'd0);
      check_eq({tag, "_err"}, 32'(bus_err_o), 32'd0);
      check_eq({tag, "_mis"}, 32'(misalign_o), 32'd0);
   endtask

   // One instruction in MEM: g = REQ cycles before the grant cycle, r = WAIT cycles
   // before the rvalid cycle. Expected results come from size/offset arithmetic.
   task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic memrw, input logic valid, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int g, input int r);
      logic        ld, st, mem, mis, ok, in_req, sgn;
      int          nb, n, last, off;
      logic [3:0]  be_e;
      logic [31:0] wd_e, ld_e, mask, ins;
      st   = memrw;
      ld   = !memrw && (opc == OpLoad);
      mem  = valid && (ld || st);
      nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off  = int'(addr[1:0]);
      mis  = (off % nb) != 0;
      be_e = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) wd_e[8*i +: 8] = wdata[8*(i % nb) +: 8];
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
      ld_e = (rdata >> (8 * off)) & mask;
      sgn  = !(f3 == 3'b100 || f3 == 3'b101);
      if (nb < 4 && sgn && ld_e[8*nb-1]) ld_e = ld_e | ~mask;
      n    = g + r + 2;
      ok   = (n <= T - 1);
      last = ok ? n : T - 1;

      ins         = $urandom;
      ins[14:12]  = f3;
      ins[6:0]    = opc;
      @(negedge clk_i);
      valid_i       = valid;
      instr_i       = ins;
      addr_i        = addr;
      wdata_i       = wdata;
      memrw_i       = memrw;
      dmem_rdata_i  = rdata;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'($urandom % 2);
      #1;
      if (!mem) begin
         check_quiet({tag, "_nomem"});
         return;
      end
      if (mis) begin
         check_eq({tag, "_mis"}, 32'(misalign_o), 32'd1);
         check_eq({tag, "_mis_stall"}, 32'(stall_o), 32'd0);
         check_eq({tag, "_mis_req"}, 32'(dmem_req_o), 32'd0);
         return;
      end
      check_eq({tag, "_idle_stall"}, 32'(stall_o), 32'd1);
      check_eq({tag, "_idle_req"}, 32'(dmem_req_o), 32'd0);
      check_eq({tag, "_idle_mis"}, 32'(misalign_o), 32'd0);

      for (int k = 1; k <= last; k++) begin
         @(negedge clk_i);
         in_req        = (k <= g + 1);
         dmem_gnt_i    = in_req && (k == g + 1);
         dmem_rvalid_i = in_req ? (k != g + 1) && 1'($urandom % 2) : (k == n);
         #1;
         check_eq({tag, "_bus_stall"}, 32'(stall_o), 32'd1);
         check_eq({tag, "_bus_req"}, 32'(dmem_req_o), 32'(in_req));
         check_eq({tag, "_bus_ldv"}, 32'(ld_valid_o), 32'd0);
         if (in_req) begin
            check_eq({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
            check_eq({tag, "_we"}, 32'(dmem_we_o), 32'(st));
            if (st) begin
               check_eq({tag, "_be"}, 32'(dmem_be_o), 32'(be_e));
               check_eq({tag, "_wdata"}, dmem_wdata_o, wd_e);
            end
         end
      end

      @(negedge clk_i);
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'($urandom % 2);
      #1;
      check_eq({tag, "_done_stall"}, 32'(stall_o), 32'd0);
      check_eq({tag, "_done_req"}, 32'(dmem_req_o), 32'd0);
      check_eq({tag, "_done_ldv"}, 32'(ld_valid_o), 32'(ld && ok));
      check_eq({tag, "_done_err"}, 32'(bus_err_o), 32'(!ok));
      if (ld && ok) check_eq({tag, "_ldata"}, ld_data_o, ld_e);
   endtask

   initial begin
      logic [6:0] opc;
      logic       rw;
      int         sel, g;
      rst_ni        = 1'b0;
      valid_i       = 1'b0;
      instr_i       = '0;
      addr_i        = '0;
      wdata_i       = '0;
      memrw_i       = 1'b0;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_quiet("reset");
      check_eq("reset_ldata", ld_data_o, 32'd0);
      rst_ni = 1'b1;

      run_op("lb",    OpLoad,  3'b000, 1'b0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
      run_op("lhu",   OpLoad,  3'b101, 1'b0, 1'b1, 32'h102, 32'h0, 32'hBEEF_1234, 0, 0);
      run_op("lh",    OpLoad,  3'b001, 1'b0, 1'b1, 32'h102, 32'h0, 32'hBEEF_1234, 0, 0);
      run_op("sb",    OpStore, 3'b000, 1'b1, 1'b1, 32'h201, 32'hAB, 32'h0, 0, 0);
      run_op("lw_mis", OpLoad, 3'b010, 1'b0, 1'b1, 32'h102, 32'h0, 32'h0, 0, 0);
      run_op("tmo",   OpLoad,  3'b010, 1'b0, 1'b1, 32'h400, 32'h0, 32'h1234_5678, 20, 0);
      run_op("alu",   OpAlu,   3'b000, 1'b0, 1'b1, 32'h100, 32'h0, 32'h0, 0, 0);

      // Reset while waiting for the response; the late rvalid must be ignored.
      @(negedge clk_i);
      valid_i = 1'b1; instr_i = {17'd0, 3'b000, 5'd1, OpLoad}; addr_i = 32'h100;
      memrw_i = 1'b0; dmem_rdata_i = 32'h0000_00FF;
      @(negedge clk_i);
      dmem_gnt_i = 1'b1;
      @(negedge clk_i);
      dmem_gnt_i = 1'b0; rst_ni = 1'b0; valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1; dmem_rvalid_i = 1'b1;
      #1;
      check_quiet("rst_mid");
      check_eq("rst_mid_ldata", ld_data_o, 32'd0);
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      #1;
      check_quiet("rst_post");

      for (int i = 0; i < 250; i++) begin
         sel = int'($urandom % 4);
         opc = (sel < 2) ? OpLoad : (sel == 2) ? OpStore : OpAlu;
         rw  = (sel == 2);
         g   = ($urandom % 6 == 0) ? 5 : int'($urandom % 3);
         run_op("rnd", opc, 3'($urandom), rw, ($urandom % 8) != 0,
                {22'($urandom), 8'h00, 2'($urandom)} | (32'($urandom % 4) << 2),
                $urandom, $urandom, g, int'($urandom % 3));
      end

      @(negedge clk_i);
      valid_i = 1'b0;
      @(negedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
